iter_frame_writer: RTL

- Upstream neighbour of the colour-mapping stage.
- Accepts the Mandelbrot engine's per-pixel iteration counts as a valid/ready stream.
- Writes the counts into the iteration buffer in DDR through one MCB write port and command port, in bursts of up to BURST_LEN 32-bit words.
- The colour stage later reads the same region back, starting at byte address 0.

---
 rtl/mandel_mem_pkg.sv | 31 +++
 rtl/iter_frame_writer_burst_calc.sv | 30 +++
 rtl/iter_frame_writer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mandel_mem_pkg.sv
// Shared memory-map constants, MCB opcodes and writer state encodings for the Mandelbrot memory path.
package mandel_mem_pkg;

  typedef enum logic [2:0] {
    ST_CAL   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FILL  = 3'd2,
    ST_CMD   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } wr_state_e;

  localparam logic [2:0]  MCB_INSTR_WRITE = 3'b000;
  localparam logic [2:0]  MCB_INSTR_READ  = 3'b001;

  localparam logic [29:0] ITER_BUF_BASE  = 30'd0;
  localparam logic [29:0] FRAME_BUF_BASE = 30'd5242880;

  localparam logic [20:0] PIX_640X480   = 21'd307200;
  localparam logic [20:0] PIX_800X600   = 21'd480000;
  localparam logic [20:0] PIX_1024X768  = 21'd786432;
  localparam logic [20:0] PIX_1280X720  = 21'd921600;
  localparam logic [20:0] PIX_1280X1024 = 21'd1310720;

  // Byte address of a 32-bit word; anything beyond 30 bits is dropped.
  function automatic logic [29:0] word_byte_addr(input logic [29:0] base,
                                                 input logic [20:0] word_idx);
    return base + {7'd0, word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/iter_frame_writer_burst_calc.sv
// Combinational burst sizing: words in the current burst, the word pointer after it,
// and whether it closes the frame.
module iter_frame_writer_burst_calc
  import mandel_mem_pkg::*;
#(
  parameter int BURST_LEN = 64
) (
  input  logic [20:0] tp_lat,
  input  logic [20:0] word_ptr,
  output logic [6:0]  amount,
  output logic [20:0] next_ptr,
  output logic        last_burst
);

  localparam logic [20:0] BURST_LEN_W = 21'(BURST_LEN);

  logic [20:0] remaining;

  always_comb begin
    remaining = tp_lat - word_ptr;
    if (remaining < BURST_LEN_W) begin
      amount = remaining[6:0];
    end else begin
      amount = BURST_LEN_W[6:0];
    end
    next_ptr   = word_ptr + {14'd0, amount};
    last_burst = (next_ptr == tp_lat);
  end

endmodule

// File: rtl/iter_frame_writer.sv
// Streams per-pixel iteration counts into the DDR iteration buffer through one MCB write/command port.
// Optional debug LEDs (state + frame count) enabled by defining ITER_FRAME_WRITER_DEBUG_EN.
module iter_frame_writer
  import mandel_mem_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR = ITER_BUF_BASE,
  parameter int          BURST_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic [20:0] total_pixels,
  input  logic        frame_start,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  input  logic        wr_empty,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  led
);

  wr_state_e   state_q, state_d;
  logic [1:0]  calib_sync_q;
  logic        calib_s;
  logic [20:0] tp_lat_q, tp_lat_d;
  logic [20:0] word_ptr_q, word_ptr_d;
  logic [6:0]  fill_cnt_q, fill_cnt_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [5:0]  cmd_bl_q, cmd_bl_d;
  logic [29:0] cmd_addr_q, cmd_addr_d;

  logic [6:0]  amount;
  logic [20:0] next_ptr;
  logic        last_burst;
  logic        accept;

  iter_frame_writer_burst_calc #(
    .BURST_LEN (BURST_LEN)
  ) u_burst_calc (
    .tp_lat     (tp_lat_q),
    .word_ptr   (word_ptr_q),
    .amount     (amount),
    .next_ptr   (next_ptr),
    .last_burst (last_burst)
  );

  // mem_calib_done comes from the MCB clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib_sync_q <= 2'b00;
    end else begin
      calib_sync_q <= {calib_sync_q[0], mem_calib_done};
    end
  end
  assign calib_s = calib_sync_q[1];

  assign pix_ready = (state_q == ST_FILL) && !wr_full && (fill_cnt_q < amount);
  assign accept    = pix_valid && pix_ready;
  assign wr_en     = accept;
  assign wr_data   = pix_data;

  always_comb begin
    state_d      = state_q;
    tp_lat_d     = tp_lat_q;
    word_ptr_d   = word_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    cmd_bl_d     = cmd_bl_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_en       = 1'b0;

    if (accept) begin
      fill_cnt_d = fill_cnt_q + 7'd1;
    end

    case (state_q)
      ST_CAL: begin
        if (calib_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (frame_start) begin
          tp_lat_d   = total_pixels;
          word_ptr_d = 21'd0;
          busy_d     = 1'b1;
          state_d    = (total_pixels == 21'd0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        // Burst length/address are loaded here so they are stable for the whole CMD wait.
        if (fill_cnt_q == amount) begin
          cmd_bl_d   = 6'(amount - 7'd1);
          cmd_addr_d = word_byte_addr(BASE_ADDR, word_ptr_q);
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!cmd_full) begin
          cmd_en  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wr_empty) begin
          word_ptr_d = next_ptr;
          fill_cnt_d = 7'd0;
          state_d    = last_burst ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_CAL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CAL;
      tp_lat_q     <= 21'd0;
      word_ptr_q   <= 21'd0;
      fill_cnt_q   <= 7'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_bl_q     <= 6'd0;
      cmd_addr_q   <= 30'd0;
    end else begin
      state_q      <= state_d;
      tp_lat_q     <= tp_lat_d;
      word_ptr_q   <= word_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cmd_bl_q     <= cmd_bl_d;
      cmd_addr_q   <= cmd_addr_d;
    end
  end

  assign cmd_instr     = MCB_INSTR_WRITE;
  assign cmd_bl        = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

`ifdef ITER_FRAME_WRITER_DEBUG_EN
  logic [4:0] frame_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 5'd0;
    end else if (frame_done_q) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  assign led = {frame_cnt_q, state_q};
`else
  assign led = 8'd0;
`endif

endmodule
